// File: rtl/dbg_trace_pkg.sv
// Shared types for execute-stage trace transmit: record layout, header, serializer states.
package dbg_trace_pkg;

   // Byte lengths of the four record shapes (header + pc + result [+ bj_pc] [+ cause + tval])
   localparam int unsigned LEN_PLAIN  = 17;
   localparam int unsigned LEN_BJ     = 25;
   localparam int unsigned LEN_EXC    = 26;
   localparam int unsigned LEN_BJ_EXC = 34;

   // Header byte: bit0 = bj, bit1 = exc, bit2 = wfi, bits 7:3 = rd
   typedef struct packed {
      logic [4:0] rd;
      logic       wfi;
      logic       exc;
      logic       bj;
   } trace_hdr_t;

   typedef struct packed {
      trace_hdr_t  hdr;
      logic [63:0] pc;
      logic [63:0] result;
      logic [63:0] bj_pc;
      logic [4:0]  cause;
      logic [63:0] tval;
   } trace_rec_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PC,
      ST_RES,
      ST_BJ,
      ST_EXC_C,
      ST_TVAL
   } tx_state_e;

   // Byte presented on the link for a given record, state and little-endian byte index
   function automatic logic [7:0] rec_byte(trace_rec_t rec, tx_state_e st, logic [2:0] idx);
      logic [5:0] bit_lo;
      bit_lo = {idx, 3'b000};
      case (st)
         ST_HDR:   rec_byte = rec.hdr;
         ST_PC:    rec_byte = rec.pc[bit_lo +: 8];
         ST_RES:   rec_byte = rec.result[bit_lo +: 8];
         ST_BJ:    rec_byte = rec.bj_pc[bit_lo +: 8];
         ST_EXC_C: rec_byte = {3'b000, rec.cause};
         ST_TVAL:  rec_byte = rec.tval[bit_lo +: 8];
         default:  rec_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO of trace records; caller guarantees no
// push when full (unless popping) and no pop when empty.
module trace_fifo
   import dbg_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  trace_rec_t               wr_data,
   input  logic                     pop,
   output trace_rec_t               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   trace_rec_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Record storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/exec_trace_tx.sv
// Execute-stage trace transmitter: captures one record per retired instruction into a
// FIFO and serializes it as a byte stream over a valid/ready link.
module exec_trace_tx
   import dbg_trace_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DROP_W = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              stall,
   input  logic [63:0]       pc,
   input  logic [4:0]        rd,
   input  logic [63:0]       result,
   input  logic              bj_en,
   input  logic [63:0]       bj_pc,
   input  logic              exc_en,
   input  logic [4:0]        cause,
   input  logic [63:0]       tval,
   input  logic              wfi_op,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              wfi_drained
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          capture;
   logic          push;
   logic          pop;
   logic          drop;
   logic          hs;
   logic          last;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   trace_rec_t    cap_rec;
   trace_rec_t    fifo_rec;
   trace_rec_t    rec;
   trace_rec_t    rec_next;
   tx_state_e     state;
   tx_state_e     state_next;
   logic [2:0]    idx;
   logic [2:0]    idx_next;

   // A pop in the same cycle frees a slot, so a capture into a full FIFO still lands
   assign capture    = valid & ~stall;
   assign push       = capture & (~fifo_full | pop);
   assign drop       = capture & fifo_full & ~pop;
   assign hs         = tx_valid & tx_ready;
   assign rec_next   = pop ? fifo_rec : rec;
   assign count_next = fifo_count + CW'(push) - CW'(pop);

   // Assemble the captured record from the execute-stage signals
   always_comb begin
      cap_rec        = '0;
      cap_rec.hdr.rd = rd;
      cap_rec.hdr.wfi = wfi_op;
      cap_rec.hdr.exc = exc_en;
      cap_rec.hdr.bj  = bj_en;
      cap_rec.pc     = pc;
      cap_rec.result = result;
      cap_rec.bj_pc  = bj_pc;
      cap_rec.cause  = cause;
      cap_rec.tval   = tval;
   end

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (cap_rec),
      .pop     (pop),
      .rd_data (fifo_rec),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Serializer next state; the byte index wraps 7->0 so each multi-byte section starts at 0
   always_comb begin
      state_next = state;
      idx_next   = idx;
      last       = 1'b0;
      pop        = 1'b0;
      case (state)
         ST_IDLE: ;
         ST_HDR: begin
            if (hs) begin
               state_next = ST_PC;
               idx_next   = '0;
            end
         end
         ST_PC: begin
            if (hs) begin
               idx_next = idx + 3'd1;
               if (idx == 3'd7) state_next = ST_RES;
            end
         end
         ST_RES: begin
            if (hs) begin
               idx_next = idx + 3'd1;
               if (idx == 3'd7) begin
                  if (rec.hdr.bj)       state_next = ST_BJ;
                  else if (rec.hdr.exc) state_next = ST_EXC_C;
                  else                  last = 1'b1;
               end
            end
         end
         ST_BJ: begin
            if (hs) begin
               idx_next = idx + 3'd1;
               if (idx == 3'd7) begin
                  if (rec.hdr.exc) state_next = ST_EXC_C;
                  else             last = 1'b1;
               end
            end
         end
         ST_EXC_C: begin
            if (hs) begin
               state_next = ST_TVAL;
               idx_next   = '0;
            end
         end
         ST_TVAL: begin
            if (hs) begin
               idx_next = idx + 3'd1;
               if (idx == 3'd7) last = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // Load the next record from IDLE or directly after a record's final byte
      if ((state == ST_IDLE) || last) begin
         if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_HDR;
         end else begin
            state_next = ST_IDLE;
         end
      end
   end

   // Serializer state plus registered link outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         rec         <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         wfi_drained <= 1'b0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         rec         <= rec_next;
         tx_valid    <= (state_next != ST_IDLE);
         tx_data     <= rec_byte(rec_next, state_next, idx_next);
         busy        <= (state_next != ST_IDLE) || (count_next != '0);
         wfi_drained <= last & rec.hdr.wfi;
      end
   end

   // Saturating count of records lost to a full FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_exec_trace_tx.sv
// Directed self-checking bench for exec_trace_tx.
`timescale 1ns/1ps
module tb_exec_trace_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        stall = 1'b0;
   logic [63:0] pc = '0;
   logic [4:0]  rd = '0;
   logic [63:0] result = '0;
   logic        bj_en = 1'b0;
   logic [63:0] bj_pc = '0;
   logic        exc_en = 1'b0;
   logic [4:0]  cause = '0;
   logic [63:0] tval = '0;
   logic        wfi_op = 1'b0;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic [15:0] drop_cnt;
   logic        wfi_drained;

   int          n_checks = 0;
   int          n_fail = 0;
   int          wfi_pulses = 0;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   exec_trace_tx #(
      .DEPTH  (8),
      .DROP_W (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (valid),
      .stall       (stall),
      .pc          (pc),
      .rd          (rd),
      .result      (result),
      .bj_en       (bj_en),
      .bj_pc       (bj_pc),
      .exc_en      (exc_en),
      .cause       (cause),
      .tval        (tval),
      .wfi_op      (wfi_op),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .drop_cnt    (drop_cnt),
      .wfi_drained (wfi_drained)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected byte stream for one record, built straight from the record format
   task automatic model_rec(input logic [63:0] p, input logic [4:0] r, input logic [63:0] res,
                            input logic b, input logic [63:0] bp, input logic e,
                            input logic [4:0] c, input logic [63:0] tv, input logic w);
      exp_q.push_back({r, w, e, b});
      for (int i = 0; i < 8; i++) exp_q.push_back(p[8*i +: 8]);
      for (int i = 0; i < 8; i++) exp_q.push_back(res[8*i +: 8]);
      if (b) for (int i = 0; i < 8; i++) exp_q.push_back(bp[8*i +: 8]);
      if (e) begin
         exp_q.push_back({3'b000, c});
         for (int i = 0; i < 8; i++) exp_q.push_back(tv[8*i +: 8]);
      end
   endtask

   // One capture cycle, entered and left at a negedge
   task automatic retire(input logic [63:0] p, input logic [4:0] r, input logic [63:0] res,
                         input logic b, input logic [63:0] bp, input logic e,
                         input logic [4:0] c, input logic [63:0] tv, input logic w,
                         input bit keep);
      pc = p; rd = r; result = res; bj_en = b; bj_pc = bp;
      exc_en = e; cause = c; tval = tv; wfi_op = w;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      if (keep) model_rec(p, r, res, b, bp, e, c, tv, w);
   endtask

   // Collect nbytes accepted bytes; checks hold stability whenever the sink stalls
   task automatic drain(input int nbytes, input bit rand_ready, input string tag);
      int         cycles = 0;
      bit         stalled = 1'b0;
      logic [7:0] held = '0;
      got_q.delete();
      wfi_pulses = 0;
      while (got_q.size() < nbytes) begin
         @(negedge clk);
         if (wfi_drained) wfi_pulses++;
         if (stalled) begin
            check({tag, "_hold_valid"}, tx_valid, 1);
            check({tag, "_hold_data"}, tx_data, held);
         end
         tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         stalled = tx_valid && !tx_ready;
         held = tx_data;
         cycles++;
         if (cycles > 2000) begin
            check({tag, "_timeout_bytes"}, got_q.size(), nbytes);
            break;
         end
      end
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_wfi_drained", wfi_drained, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain retire: 17 bytes, 2-cycle first-byte latency
      exp_q.delete();
      retire(64'h8000_0000, 5'd10, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0, 0, 1);
      check("t1_busy_after_cap", busy, 1);
      check("t1_valid_lat1", tx_valid, 0);
      @(negedge clk);
      check("t1_valid_lat2", tx_valid, 1);
      check("t1_first_hdr", tx_data, 8'h50);
      drain(17, 0, "t1");
      check("t1_b0", got_q[0], 8'h50);
      check("t1_b4", got_q[4], 8'h80);
      check("t1_b8", got_q[8], 8'h00);
      check("t1_b9", got_q[9], 8'h88);
      check("t1_b16", got_q[16], 8'h11);
      check_stream("t1");
      check("t1_busy_end", busy, 0);
      check("t1_valid_end", tx_valid, 0);

      // Taken branch with exception: 34 bytes
      exp_q.delete();
      retire(64'h8000_0004, 5'd1, 64'h0, 1, 64'h8000_0040, 1, 5'd2, 64'hDEAD, 0, 1);
      drain(34, 0, "t2");
      check("t2_hdr", got_q[0], 8'h0B);
      check("t2_b17", got_q[17], 8'h40);
      check("t2_b20", got_q[20], 8'h80);
      check("t2_b25", got_q[25], 8'h02);
      check("t2_b26", got_q[26], 8'hAD);
      check("t2_b27", got_q[27], 8'hDE);
      check("t2_b28", got_q[28], 8'h00);
      check_stream("t2");

      // Four back-to-back records of every shape with random sink readiness
      exp_q.delete();
      retire(64'h1111_2222_3333_4444, 5'd5, 64'hA5A5_0000_FFFF_0001, 0, 0, 0, 0, 0, 0, 1);
      retire(64'h0000_0000_0000_0100, 5'd31, 64'h0123_4567_89AB_CDEF, 1, 64'hCAFE_F00D_0000_0200, 0, 0, 0, 0, 1);
      retire(64'h0000_0000_0000_0300, 5'd0, 64'h7, 0, 0, 1, 5'd13, 64'hFEED_BEEF_1234_5678, 0, 1);
      retire(64'h0000_0000_0000_0400, 5'd17, 64'h8, 1, 64'h0000_0000_0000_0480, 1, 5'd31, 64'h1, 0, 1);
      drain(102, 1, "t3");
      check_stream("t3");
      check("t3_busy_end", busy, 0);

      // Overflow: ten captures with the sink stalled, one dropped
      exp_q.delete();
      for (int k = 0; k < 10; k++)
         retire(64'h1000 + 64'(4 * k), 5'(k + 1), 64'h0101_0101_0101_0101 * 64'(k), 0, 0, 0, 0, 0, 0, k < 9);
      @(negedge clk);
      check("t4_drop_cnt", drop_cnt, 1);
      check("t4_held_valid", tx_valid, 1);
      check("t4_held_hdr", tx_data, 8'h08);
      check("t4_busy", busy, 1);
      drain(153, 0, "t4");
      check_stream("t4");
      repeat (3) @(negedge clk);
      check("t4_valid_end", tx_valid, 0);
      check("t4_busy_end", busy, 0);
      check("t4_drop_keep", drop_cnt, 1);

      // WFI record: one drained pulse after the final byte
      exp_q.delete();
      retire(64'h8000_0100, 5'd0, 64'h0, 0, 0, 0, 0, 0, 1, 1);
      drain(17, 0, "t5");
      check("t5_hdr", got_q[0], 8'h04);
      check("t5_no_early_pulse", wfi_pulses, 0);
      check("t5_wfi_pulse", wfi_drained, 1);
      @(negedge clk);
      check("t5_wfi_pulse_end", wfi_drained, 0);
      check_stream("t5");

      // Reset during byte 5, then stalled retire ignored, then clean record
      exp_q.delete();
      retire(64'h0706_0504_0302_0100, 5'd3, 64'h9, 0, 0, 0, 0, 0, 0, 0);
      drain(5, 0, "t6a");
      check("t6_byte5_before_rst", tx_data, 8'h04);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", tx_valid, 0);
      check("t6_rst_data", tx_data, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_drop", drop_cnt, 0);
      check("t6_rst_wfi", wfi_drained, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pc = 64'hBAD; rd = 5'd9; valid = 1'b1; stall = 1'b1;
      repeat (3) @(negedge clk);
      valid = 1'b0; stall = 1'b0;
      check("t6_stall_busy", busy, 0);
      check("t6_stall_valid", tx_valid, 0);
      retire(64'h8000_0200, 5'd7, 64'h55, 0, 0, 0, 0, 0, 0, 1);
      drain(17, 0, "t6b");
      check("t6_hdr", got_q[0], 8'h38);
      check_stream("t6b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
